lfsr_stream: RTL



---
 rtl/lfsr_stream_if.sv | 11 +
 rtl/lfsr_stream.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/lfsr_stream_if.sv
// Ready/valid word stream carrying pseudo-random data from lfsr_stream to its consumer.
interface lfsr_stream_if #(
  parameter int STEPS = 8
);
  logic             valid;
  logic             ready;
  logic [STEPS-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/lfsr_stream.sv
// Galois LFSR word generator (STEPS bits per accepted word) with seed load and lock-up recovery.
// Define LFSR_STREAM_CHECK_EN to add a PRBS checker that tracks its own reference LFSR.
module lfsr_stream #(
  parameter int               WIDTH  = 16,
  parameter logic [WIDTH-1:0] TAPS   = 16'hB400,
  parameter int               STEPS  = 8,
  parameter int               INVERT = 0,
  parameter logic [WIDTH-1:0] SEED   = '1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seed_load_i,
  input  logic [WIDTH-1:0]   seed_i,
  lfsr_stream_if.master      out_if,
  output logic [WIDTH-1:0]   state_o,
  output logic               lockup_o,
  output logic [31:0]        word_count_o
`ifdef LFSR_STREAM_CHECK_EN
  ,
  input  logic               chk_valid_i,
  input  logic [STEPS-1:0]   chk_data_i,
  output logic [15:0]        chk_errors_o,
  output logic [31:0]        chk_words_o
`endif
);

  localparam logic INV_BIT = (INVERT != 0);

  function automatic logic feedback(input logic [WIDTH-1:0] s);
    return s[WIDTH-1] ^ INV_BIT;
  endfunction

  function automatic logic [WIDTH-1:0] stepState(input logic [WIDTH-1:0] s);
    return {s[WIDTH-2:0], 1'b0} ^ (feedback(s) ? TAPS : '0);
  endfunction

  // Unrolled STEPS shifts: returns {word, advanced state}, first bit in the word MSB.
  function automatic logic [STEPS+WIDTH-1:0] advance(input logic [WIDTH-1:0] s);
    logic [WIDTH-1:0] cur;
    logic [STEPS-1:0] bits;
    cur  = s;
    bits = '0;
    for (int i = 0; i < STEPS; i++) begin
      bits[STEPS-1-i] = feedback(cur);
      cur             = stepState(cur);
    end
    return {bits, cur};
  endfunction

  localparam logic [WIDTH-1:0] SEED_STEP = stepState(SEED);

  if (SEED_STEP == SEED) begin : gBadSeed
    $error("lfsr_stream: SEED is a fixed point of the configured LFSR");
  end

  typedef enum logic [1:0] {PRIME, RUN, RECOVER} genState_e;

  genState_e        fsm_q;
  logic [WIDTH-1:0] lfsr_q;
  logic [STEPS-1:0] word_q;
  logic             valid_q;
  logic             lockup_q;
  logic [31:0]      wordCount_q;

  logic [STEPS-1:0] genWord_d;
  logic [WIDTH-1:0] genState_d;

  always_comb begin
    {genWord_d, genState_d} = advance(lfsr_q);
  end

  // seed_load outranks a pending transfer, so a word offered in that cycle is dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm_q       <= PRIME;
      lfsr_q      <= SEED;
      word_q      <= '0;
      valid_q     <= 1'b0;
      lockup_q    <= 1'b0;
      wordCount_q <= '0;
    end else if (seed_load_i) begin
      fsm_q       <= PRIME;
      lfsr_q      <= seed_i;
      valid_q     <= 1'b0;
      lockup_q    <= 1'b0;
      wordCount_q <= '0;
    end else begin
      case (fsm_q)
        PRIME: begin
          if (stepState(lfsr_q) == lfsr_q) begin
            lfsr_q   <= SEED;
            lockup_q <= 1'b1;
            fsm_q    <= RECOVER;
          end else begin
            word_q  <= genWord_d;
            lfsr_q  <= genState_d;
            valid_q <= 1'b1;
            fsm_q   <= RUN;
          end
        end
        RECOVER: fsm_q <= PRIME;
        RUN: begin
          if (valid_q && out_if.ready) begin
            word_q      <= genWord_d;
            lfsr_q      <= genState_d;
            wordCount_q <= wordCount_q + 32'd1;
          end
        end
        default: fsm_q <= PRIME;
      endcase
    end
  end

  assign out_if.valid = valid_q;
  assign out_if.data  = word_q;
  assign state_o      = lfsr_q;
  assign lockup_o     = lockup_q;
  assign word_count_o = wordCount_q;

`ifdef LFSR_STREAM_CHECK_EN
  logic [WIDTH-1:0] chkRef_q;
  logic [15:0]      chkErrors_q;
  logic [31:0]      chkWords_q;

  logic [STEPS-1:0] chkWord_d;
  logic [WIDTH-1:0] chkState_d;
  logic [16:0]      errSum_d;

  always_comb begin
    {chkWord_d, chkState_d} = advance(chkRef_q);
    errSum_d = {1'b0, chkErrors_q} + 17'($countones(chkWord_d ^ chk_data_i));
  end

  // The error count saturates rather than wrapping so a long bad run stays visible.
  always_ff @(posedge clk) begin
    if (reset) begin
      chkRef_q    <= SEED;
      chkErrors_q <= '0;
      chkWords_q  <= '0;
    end else if (seed_load_i) begin
      chkRef_q <= seed_i;
    end else if (chk_valid_i) begin
      chkRef_q    <= chkState_d;
      chkErrors_q <= errSum_d[16] ? 16'hFFFF : errSum_d[15:0];
      chkWords_q  <= chkWords_q + 32'd1;
    end
  end

  assign chk_errors_o = chkErrors_q;
  assign chk_words_o  = chkWords_q;
`endif

endmodule
